// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared widths and sequencer state encoding for the ADC scan path
package adc_pkg;
  localparam int N_CH   = 8;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE
  } seq_state_e;
endpackage

// File: rtl/adc_result_bank.sv
// rtl/adc_result_bank.sv - per-channel latest-result registers with valid bits
module adc_result_bank
  import adc_pkg::*;
(
  input  logic              clk_16M,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [DATA_W-1:0] mem [N_CH];
  logic [N_CH-1:0]   valid;

  always_ff @(posedge clk_16M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) mem[i] <= '0;
      valid <= '0;
    end else if (we) begin
      mem[waddr]   <= wdata;
      valid[waddr] <= 1'b1;
    end
  end

  // Read is purely combinational, so a same-cycle write is seen one cycle later.
  assign rdata  = mem[raddr];
  assign rvalid = valid[raddr];

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - steps the ADC SPI engine through mask-selected channels
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int SCAN_DIV = 16000,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk_16M,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en_mask,
  input  logic              auto_en,
  input  logic              scan_req,
  output logic              conv_start,
  output logic [ADDR_W-1:0] conv_addr,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] conv_data,
  input  logic [ADDR_W-1:0] rd_chan,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              scan_done,
  output logic              busy,
  output logic              err_timeout
);

  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int WAIT_W = $clog2(TIMEOUT);

  seq_state_e        state_q, state_d;
  logic [TICK_W-1:0] tick_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [N_CH-1:0]   mask_q;
  logic [ADDR_W-1:0] cur_q, pend_addr_q;
  logic              pend_v_q, flush_q, err_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] start_first, mask_first, next_addr;
  logic              next_hit, tick, start, timeout_hit;

  assign tick        = (tick_cnt == TICK_W'(SCAN_DIV - 1));
  assign start       = (tick && auto_en) || scan_req;
  assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_16M or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Descending sweep leaves the lowest qualifying index in each result.
  always_comb begin
    start_first = '0;
    mask_first  = '0;
    next_addr   = '0;
    next_hit    = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_mask[i]) start_first = ADDR_W'(i);
      if (mask_q[i])  mask_first  = ADDR_W'(i);
      if (mask_q[i] && (i > int'(cur_q))) begin
        next_hit  = 1'b1;
        next_addr = ADDR_W'(i);
      end
    end
  end

  always_ff @(posedge clk_16M or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && (en_mask != '0)) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (conv_done)        state_d = ST_STORE;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_STORE: state_d = flush_q ? ST_IDLE : ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_16M or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      cur_q       <= '0;
      pend_addr_q <= '0;
      pend_v_q    <= 1'b0;
      flush_q     <= 1'b0;
      err_q       <= 1'b0;
      wait_cnt    <= '0;
      data_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_q <= en_mask;
            if (en_mask != '0) begin
              err_q    <= 1'b0;
              pend_v_q <= 1'b0;
              flush_q  <= 1'b0;
              cur_q    <= start_first;
            end
          end
        end
        // wait_cnt holds cycles elapsed since the conv_start pulse.
        ST_ISSUE: wait_cnt <= WAIT_W'(1);
        ST_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (conv_done)        data_q <= conv_data;
          else if (timeout_hit) err_q  <= 1'b1;
        end
        ST_STORE: begin
          // Data returned in this frame belongs to the address sent one frame earlier.
          pend_addr_q <= cur_q;
          pend_v_q    <= ~flush_q;
          if (!flush_q) begin
            if (next_hit) begin
              cur_q <= next_addr;
            end else begin
              flush_q <= 1'b1;
              cur_q   <= mask_first;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign conv_start  = (state_q == ST_ISSUE);
  assign conv_addr   = cur_q;
  assign busy        = (state_q != ST_IDLE);
  assign scan_done   = (state_q == ST_STORE) && flush_q;
  assign err_timeout = err_q;

  adc_result_bank u_bank (
    .clk_16M (clk_16M),
    .rst_n   (rst_n),
    .we      ((state_q == ST_STORE) && pend_v_q),
    .waddr   (pend_addr_q),
    .wdata   (data_q),
    .raddr   (rd_chan),
    .rdata   (rd_data),
    .rvalid  (rd_valid)
  );

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - scoreboard bench for adc_scan_sequencer
`timescale 1ns/1ps
module tb_adc_scan_sequencer;
  localparam int SCAN_DIV = 100;
  localparam int TIMEOUT  = 64;

  logic        clk_16M = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  en_mask = '0;
  logic        auto_en = 1'b0;
  logic        scan_req = 1'b0;
  logic        conv_start;
  logic [2:0]  conv_addr;
  logic        conv_done = 1'b0;
  logic [11:0] conv_data = '0;
  logic [2:0]  rd_chan = '0;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        scan_done;
  logic        busy;
  logic        err_timeout;

  always #5 clk_16M = ~clk_16M;

  adc_scan_sequencer #(.SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk_16M(clk_16M), .rst_n(rst_n), .en_mask(en_mask), .auto_en(auto_en),
    .scan_req(scan_req), .conv_start(conv_start), .conv_addr(conv_addr),
    .conv_done(conv_done), .conv_data(conv_data), .rd_chan(rd_chan),
    .rd_data(rd_data), .rd_valid(rd_valid), .scan_done(scan_done),
    .busy(busy), .err_timeout(err_timeout)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int exp_addr_q[$];
  int exp_frames_q[$];
  int start_cyc_q[$];
  int frames = 0;
  int last_start_cyc = 0;
  logic [11:0] eng_salt = '0;
  logic [2:0]  eng_prev = '0;
  bit          withhold = 1'b0;
  logic [11:0] bank_m [8];
  bit          valid_m [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk_16M) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT issues a frame or finishes a scan.
  always @(negedge clk_16M) begin
    if (rst_n) begin
      if (conv_start) begin
        frames++;
        last_start_cyc = cyc;
        start_cyc_q.push_back(cyc);
        if (exp_addr_q.size() == 0) check("unexpected_conv_start", 1, 0);
        else check("conv_addr", conv_addr, exp_addr_q.pop_front());
      end
      if (scan_done) begin
        if (exp_frames_q.size() == 0) check("unexpected_scan_done", 1, 0);
        else check("frames_per_scan", frames, exp_frames_q.pop_front());
      end
      if (!busy) frames = 0;
    end else begin
      frames = 0;
    end
  end

  // SPI engine model: returns salt + the address it was sent one frame earlier.
  initial begin
    int lat;
    logic [2:0] a;
    forever begin
      @(negedge clk_16M);
      if (rst_n && conv_start && !withhold) begin
        a = conv_addr;
        lat = $urandom_range(1, 8);
        repeat (lat) @(posedge clk_16M);
        #1;
        if (rst_n) begin
          conv_done = 1'b1;
          conv_data = eng_salt + {9'b0, eng_prev};
          eng_prev  = a;
          @(posedge clk_16M);
          #1 conv_done = 1'b0;
        end
      end
    end
  end

  task automatic clear_model();
    for (int ch = 0; ch < 8; ch++) begin
      bank_m[ch]  = '0;
      valid_m[ch] = 1'b0;
    end
    exp_addr_q.delete();
    exp_frames_q.delete();
  endtask

  task automatic push_scan(input logic [7:0] m);
    int first;
    first = -1;
    for (int ch = 0; ch < 8; ch++)
      if (m[ch]) begin
        exp_addr_q.push_back(ch);
        if (first < 0) first = ch;
      end
    exp_addr_q.push_back(first);
    exp_frames_q.push_back($countones(m) + 1);
  endtask

  task automatic apply_scan(input logic [7:0] m, input logic [11:0] salt);
    for (int ch = 0; ch < 8; ch++)
      if (m[ch]) begin
        bank_m[ch]  = salt + 12'(ch);
        valid_m[ch] = 1'b1;
      end
  endtask

  task automatic check_bank();
    for (int ch = 0; ch < 8; ch++) begin
      rd_chan = 3'(ch);
      #1;
      check($sformatf("rd_valid[%0d]", ch), rd_valid, valid_m[ch]);
      check($sformatf("rd_data[%0d]", ch), rd_data, bank_m[ch]);
    end
  endtask

  task automatic pulse_req();
    @(posedge clk_16M);
    #1 scan_req = 1'b1;
    @(posedge clk_16M);
    #1 scan_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_16M);
    rst_n = 1'b0;
    clear_model();
    repeat (3) @(negedge clk_16M);
    rst_n = 1'b1;
  endtask

  task automatic run_scan(input logic [7:0] m, input logic [11:0] salt);
    int hi;
    bit got;
    eng_salt = salt;
    en_mask  = m;
    push_scan(m);
    hi = 0;
    for (int ch = 0; ch < 8; ch++) if (m[ch]) hi = ch;
    rd_chan = 3'(hi);
    pulse_req();
    check("busy_at_start", busy, 1);
    check("err_cleared_at_start", err_timeout, 0);
    en_mask = 8'($urandom);
    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk_16M);
      if (scan_done) got = 1'b1;
    end
    check("scan_completed", got, 1);
    if (got) check("rd_old_on_write", rd_data, bank_m[hi]);
    apply_scan(m, salt);
    @(posedge clk_16M);
    #1;
    check("busy_after_done", busy, 0);
    check_bank();
  endtask

  initial begin
    bit got, saw_done;
    int n, t;
    logic [7:0] m;
    logic [11:0] salt;

    clear_model();
    repeat (3) @(posedge clk_16M);
    #1;
    check("rst_busy", busy, 0);
    check("rst_conv_start", conv_start, 0);
    check("rst_conv_addr", conv_addr, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_err_timeout", err_timeout, 0);
    check_bank();
    @(negedge clk_16M);
    rst_n = 1'b1;

    run_scan(8'hFF, 12'h100);
    do_reset();
    run_scan(8'b1000_0010, 12'h100);

    // Empty mask: nothing may start.
    en_mask = 8'h00;
    pulse_req();
    got = 1'b0;
    repeat (20) begin
      @(negedge clk_16M);
      if (busy) got = 1'b1;
    end
    check("mask0_busy", got, 0);

    for (int s = 0; s < 8; s++)
      run_scan(8'($urandom_range(1, 255)), 12'($urandom));

    // Auto scans on tick; a scan_req during a scan must be dropped.
    salt = 12'($urandom);
    eng_salt = salt;
    en_mask = 8'h01;
    repeat (3) push_scan(8'h01);
    start_cyc_q.delete();
    auto_en = 1'b1;
    n = 0;
    for (int k = 0; k < 300 && n < 1; k++) begin
      @(negedge clk_16M);
      if (scan_done) n++;
    end
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk_16M);
      if (conv_start) got = 1'b1;
    end
    pulse_req();
    for (int k = 0; k < 300 && n < 3; k++) begin
      @(negedge clk_16M);
      if (scan_done) n++;
    end
    auto_en = 1'b0;
    check("auto_scans", n, 3);
    check("auto_frames", start_cyc_q.size(), 6);
    if (start_cyc_q.size() >= 5) begin
      check("tick_period_a", start_cyc_q[2] - start_cyc_q[0], SCAN_DIV);
      check("tick_period_b", start_cyc_q[4] - start_cyc_q[2], SCAN_DIV);
    end
    apply_scan(8'h01, salt);
    @(posedge clk_16M);
    #1;
    check_bank();

    // Withheld conv_done: abort after exactly TIMEOUT cycles.
    m = 8'($urandom_range(1, 255));
    withhold = 1'b1;
    en_mask = m;
    for (int ch = 7; ch >= 0; ch--) if (m[ch]) n = ch;
    exp_addr_q.push_back(n);
    pulse_req();
    got = 1'b0;
    saw_done = 1'b0;
    t = 0;
    for (int k = 0; k < TIMEOUT + 50 && !got; k++) begin
      @(negedge clk_16M);
      if (scan_done) saw_done = 1'b1;
      if (err_timeout) begin
        got = 1'b1;
        t = cyc;
      end
    end
    check("timeout_seen", got, 1);
    check("timeout_latency", t - last_start_cyc, TIMEOUT);
    check("busy_after_timeout", busy, 0);
    check("no_done_on_timeout", saw_done, 0);
    repeat (5) @(negedge clk_16M);
    check("err_sticky", err_timeout, 1);
    withhold = 1'b0;
    run_scan(8'($urandom_range(1, 255)), 12'($urandom));

    // Reset during the third frame of a full scan.
    eng_salt = 12'($urandom);
    en_mask = 8'hFF;
    push_scan(8'hFF);
    pulse_req();
    n = 1;
    for (int k = 0; k < 500 && n < 3; k++) begin
      @(negedge clk_16M);
      if (conv_start) n++;
    end
    check("third_frame_reached", n, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_conv_start", conv_start, 0);
    check("arst_conv_addr", conv_addr, 0);
    check("arst_scan_done", scan_done, 0);
    check("arst_err_timeout", err_timeout, 0);
    clear_model();
    check_bank();
    repeat (5) @(negedge clk_16M);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_16M);
    run_scan(8'hFF, 12'($urandom));

    check("exp_addr_drained", exp_addr_q.size(), 0);
    check("exp_frames_drained", exp_frames_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Controller that sequences the ADC128S102 SPI conversion engine through a mask-selected set of input channels, one scan per scan tick or per single-shot request. Accounts for the ADC's one-frame channel pipeline: the address sent in frame N is the channel converted in frame N+1. Stores the latest 12-bit result per channel in a register bank, read by the seven-segment path through a combinational read port. Sits between the debouncer and switch inputs and the ADC SPI engine, all in the clk_16M domain.

Parameters:
N_CH, 8, number of ADC channels (address width 3)
DATA_W, 12, conversion result width
SCAN_DIV, 16000, clk_16M cycles between auto-scan ticks (1 kHz)
TIMEOUT, 1024, max cycles from conv_start to conv_done before abort

Ports:
clk_16M  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en_mask  in  8  channel enable mask (bit i = channel i); sampled at scan start
auto_en  in  1  1 = periodic scans on tick; 0 = single-shot only
scan_req  in  1  single-cycle pulse, starts one scan (e.g. debounced pushbutton)
conv_start  out  1  single-cycle pulse to the SPI engine, starts one 16-SCK frame
conv_addr  out  3  channel address to shift out in this frame; held stable while busy
conv_done  in  1  single-cycle pulse, frame complete, conv_data valid
conv_data  in  12  result of the previous frame's address
rd_chan  in  3  read-port channel select
rd_data  out  12  stored result for rd_chan (combinational)
rd_valid  out  1  rd_chan has been written since reset
scan_done  out  1  single-cycle pulse when a scan completes
busy  out  1  high from scan start to scan_done or abort
err_timeout  out  1  sticky; set on frame timeout, cleared by the next scan start

Behaviour:
- Reset: conv_start=0, conv_addr=0, scan_done=0, busy=0, err_timeout=0, all bank entries 0, valid bits 0, tick counter 0, FSM=IDLE.
- Tick counter runs freely from 0 to SCAN_DIV-1 and wraps. The tick fires at the wrap and is acted on only when auto_en=1.
- Start condition: (tick & auto_en) | scan_req while in IDLE. Start requests arriving while busy=1 are dropped, not queued.
- On start: latch mask_q=en_mask. If mask_q==0, stay IDLE with no pulses. Otherwise clear err_timeout, set busy, set pend_v=0, set cur = lowest set bit, go to ISSUE.
- FSM states:
  - IDLE: waits for a start condition, as above.
  - ISSUE: conv_addr=cur, conv_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: count cycles. On conv_done go to STORE. If the count reaches TIMEOUT, set err_timeout, clear busy, go to IDLE with no scan_done; bank is unchanged for this frame.
  - STORE (1 cycle): if pend_v, write bank[pend_addr]=conv_data and set valid[pend_addr]. Then pend_addr=cur, pend_v=~flush.
    - If flush: pulse scan_done, clear busy, go to IDLE.
    - Else if a next set bit of mask_q exists above cur: cur=that bit, go to ISSUE.
    - Else: set flush=1, cur=lowest set bit (dummy address), go to ISSUE.
- Frames per scan = popcount(mask_q)+1. The first frame's data is discarded; the extra flush frame retrieves the last channel.
- Example: mask 8'b0000_0101 gives frame addresses 0,2,0 and writes ch0 after frame 2 and ch2 after frame 3.
- A conv_done seen outside WAIT is ignored.
- rd_data is combinational from the bank, with no added latency. A read and a write to the same channel in the same cycle returns the old value.
- en_mask changes during a scan have no effect until the next start.
- rst_n asserted mid-scan aborts immediately to reset values. The SPI engine is expected to be reset by the same rst_n.

Decomposition:
- Shared package adc_pkg: N_CH, DATA_W, ADC address width (3), and the FSM state encoding (IDLE, ISSUE, WAIT, STORE).
- One natural sub-module, adc_result_bank: 8x12 register bank plus valid bits, with a write port (we, waddr, wdata) and a combinational read port.
- Next-channel priority search (next set bit above cur, and lowest set bit) stays inline in the sequencer.

Test Plan:
- Reset, then auto_en=0, mask=8'hFF, scan_req pulse; engine model returns data = 12'h100 + address of previous frame -> 9 conv_start pulses with addresses 0..7,0; bank[i]=12'h100+i; rd_valid=1 for all; one scan_done.
- mask=8'b1000_0010, scan_req -> addresses 1,7,1; only ch1=12'h101 and ch7=12'h107 written; rd_chan=3 gives rd_valid=0, rd_data=0.
- mask=0, scan_req -> no conv_start, busy stays 0, no scan_done.
- auto_en=1, SCAN_DIV=100 in sim, mask=8'h01 -> scans start every 100 cycles, each with 2 frames; a scan_req issued while busy is ignored (frame count unchanged).
- Engine model withholds conv_done -> err_timeout=1 exactly TIMEOUT cycles after conv_start, busy=0, no scan_done; next scan_req clears err_timeout.
- rst_n pulled low during the 3rd frame of an 8-channel scan -> all outputs and the bank return to 0 asynchronously; a fresh scan after release completes normally.
